// File: rtl/stream_topk.sv
// stream_topk: per-frame streaming top-K selector for signed samples.
// Keeps a sorted insertion list of the K best samples of the current frame
// and publishes it, with occupancy and sample count, one cycle after the
// frame's last sample.
module stream_topk #(
    parameter int WIDTH   = 6,
    parameter int K       = 3,
    parameter int DESCEND = 1,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    output logic [K*WIDTH-1:0]         out_list,
    output logic [$clog2(K+1)-1:0]     out_num,
    output logic [CNT_W-1:0]           out_cnt
);

    localparam int NUM_W = $clog2(K+1);

    // Working list: slot 0 is the best value; empty slots always sit below
    // filled ones and always hold 0.
    logic signed [WIDTH-1:0] slot_q [K];
    logic signed [WIDTH-1:0] slot_d [K];
    logic [K-1:0]            vld_q;
    logic [K-1:0]            vld_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;

    logic                    out_valid_q, out_valid_d;
    logic [K*WIDTH-1:0]      out_list_q, out_list_d;
    logic [NUM_W-1:0]        out_num_q, out_num_d;
    logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;

    // Post-insertion view of the list for the sample currently offered.
    logic signed [WIDTH-1:0] x;
    logic [K-1:0]            better;
    logic [K-1:0]            ins;
    logic [K-1:0]            prev_ins;
    logic signed [WIDTH-1:0] shift_val [K];
    logic [K-1:0]            shift_vld;
    logic signed [WIDTH-1:0] new_val [K];
    logic [K-1:0]            new_vld;
    logic [NUM_W-1:0]        new_num;
    logic [CNT_W-1:0]        cnt_inc;

    // Insertion network: the insert mask is monotone (once x beats a slot it
    // beats every slot below), so the first set bit is the write position and
    // every later set bit takes the value shifted down from above. Ties are
    // not "better", so an equal sample lands below the earlier equal entries.
    always_comb begin
        x         = $signed(in_data);
        better    = '0;
        ins       = '0;
        prev_ins  = '0;
        shift_vld = '0;
        new_vld   = '0;
        new_num   = '0;
        for (int i = 0; i < K; i++) begin
            shift_val[i] = '0;
            new_val[i]   = '0;
        end
        for (int i = 0; i < K; i++) begin
            if (DESCEND != 0) begin
                better[i] = (x > slot_q[i]);
            end else begin
                better[i] = (x < slot_q[i]);
            end
            ins[i] = !vld_q[i] || better[i];
        end
        for (int i = 1; i < K; i++) begin
            prev_ins[i]  = ins[i-1];
            shift_val[i] = slot_q[i-1];
            shift_vld[i] = vld_q[i-1];
        end
        for (int i = 0; i < K; i++) begin
            if (ins[i] && !prev_ins[i]) begin
                new_val[i] = x;
                new_vld[i] = 1'b1;
            end else if (ins[i]) begin
                new_val[i] = shift_val[i];
                new_vld[i] = shift_vld[i];
            end else begin
                new_val[i] = slot_q[i];
                new_vld[i] = vld_q[i];
            end
            if (new_vld[i]) begin
                new_num = new_num + NUM_W'(1);
            end
        end
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state selection: hold on idle cycles, insert on accepted samples,
    // publish and clear the working list on an accepted last sample.
    always_comb begin
        out_valid_d = 1'b0;
        out_list_d  = out_list_q;
        out_num_d   = out_num_q;
        out_cnt_d   = out_cnt_q;
        vld_d       = vld_q;
        cnt_d       = cnt_q;
        for (int i = 0; i < K; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (in_valid) begin
            if (in_last) begin
                out_valid_d = 1'b1;
                out_num_d   = new_num;
                out_cnt_d   = cnt_inc;
                for (int i = 0; i < K; i++) begin
                    out_list_d[i*WIDTH +: WIDTH] = new_vld[i] ? new_val[i] : '0;
                    slot_d[i] = '0;
                end
                vld_d = '0;
                cnt_d = '0;
            end else begin
                for (int i = 0; i < K; i++) begin
                    slot_d[i] = new_val[i];
                end
                vld_d = new_vld;
                cnt_d = cnt_inc;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                slot_q[i] <= '0;
            end
            vld_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_list_q  <= '0;
            out_num_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                slot_q[i] <= slot_d[i];
            end
            vld_q       <= vld_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_list_q  <= out_list_d;
            out_num_q   <= out_num_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_list  = out_list_q;
    assign out_num   = out_num_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_stream_topk.sv
// Directed bench for stream_topk: three instances cover the default
// configuration, ascending K=4, and a 2-bit saturating counter.
module tb_stream_topk;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: defaults (WIDTH=6, K=3, DESCEND=1, CNT_W=8)
    logic        a_valid = 1'b0, a_last = 1'b0;
    logic [5:0]  a_data  = '0;
    logic        a_ovalid;
    logic [17:0] a_list;
    logic [1:0]  a_num;
    logic [7:0]  a_cnt;

    // Instance B: K=4, DESCEND=0
    logic        b_valid = 1'b0, b_last = 1'b0;
    logic [5:0]  b_data  = '0;
    logic        b_ovalid;
    logic [23:0] b_list;
    logic [2:0]  b_num;
    logic [7:0]  b_cnt;

    // Instance C: CNT_W=2
    logic        c_valid = 1'b0, c_last = 1'b0;
    logic [5:0]  c_data  = '0;
    logic        c_ovalid;
    logic [17:0] c_list;
    logic [1:0]  c_num;
    logic [1:0]  c_cnt;

    stream_topk u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
        .out_valid(a_ovalid), .out_list(a_list), .out_num(a_num), .out_cnt(a_cnt)
    );

    stream_topk #(.WIDTH(6), .K(4), .DESCEND(0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
        .out_valid(b_ovalid), .out_list(b_list), .out_num(b_num), .out_cnt(b_cnt)
    );

    stream_topk #(.WIDTH(6), .K(3), .DESCEND(1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_data(c_data), .in_last(c_last),
        .out_valid(c_ovalid), .out_list(c_list), .out_num(c_num), .out_cnt(c_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each drive waits for a falling edge, so the value is taken at the next
    // rising edge and outputs observed here are half a cycle past the last edge.
    task automatic drv_a(input logic v, input logic [5:0] d, input logic l);
        @(negedge clk);
        a_valid = v; a_data = d; a_last = l;
    endtask

    task automatic drv_b(input logic v, input logic [5:0] d, input logic l);
        @(negedge clk);
        b_valid = v; b_data = d; b_last = l;
    endtask

    task automatic drv_c(input logic v, input logic [5:0] d, input logic l);
        @(negedge clk);
        c_valid = v; c_data = d; c_last = l;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_a_valid", {31'd0, a_ovalid}, 32'd0);
        chk("rst_a_list",  {14'd0, a_list},   32'd0);
        chk("rst_a_num",   {30'd0, a_num},    32'd0);
        chk("rst_a_cnt",   {24'd0, a_cnt},    32'd0);
        rst = 1'b0;

        // Frame 5, -3, 12, 12, -32, 31(last) -> 31, 12, 12
        drv_a(1, 6'd5, 0);
        drv_a(1, 6'b111101, 0);
        drv_a(1, 6'd12, 0);
        drv_a(1, 6'd12, 0);
        drv_a(1, 6'b100000, 0);
        drv_a(1, 6'd31, 1);
        chk("f1_no_early_valid", {31'd0, a_ovalid}, 32'd0);
        drv_a(0, 6'd0, 0);
        chk("f1_valid", {31'd0, a_ovalid}, 32'd1);
        chk("f1_list",  {14'd0, a_list},   {14'd0, 6'd12, 6'd12, 6'd31});
        chk("f1_num",   {30'd0, a_num},    32'd3);
        chk("f1_cnt",   {24'd0, a_cnt},    32'd6);
        drv_a(0, 6'd0, 0);
        chk("f1_pulse_end", {31'd0, a_ovalid}, 32'd0);
        chk("f1_hold_list", {14'd0, a_list},   {14'd0, 6'd12, 6'd12, 6'd31});

        // Short frame -8, 3(last) -> 3, -8, 0
        drv_a(1, 6'b111000, 0);
        drv_a(0, 6'd0, 0);
        drv_a(1, 6'd3, 1);
        drv_a(0, 6'd0, 0);
        chk("f2_valid", {31'd0, a_ovalid}, 32'd1);
        chk("f2_list",  {14'd0, a_list},   {14'd0, 6'd0, 6'b111000, 6'd3});
        chk("f2_num",   {30'd0, a_num},    32'd2);
        chk("f2_cnt",   {24'd0, a_cnt},    32'd2);

        // Back-to-back: frame 1, 2(last) then frame 9(last)
        drv_a(1, 6'd1, 0);
        drv_a(1, 6'd2, 1);
        drv_a(1, 6'd9, 1);
        chk("b2b_first_valid", {31'd0, a_ovalid}, 32'd1);
        chk("b2b_first_list",  {14'd0, a_list},   {14'd0, 6'd0, 6'd1, 6'd2});
        chk("b2b_first_num",   {30'd0, a_num},    32'd2);
        chk("b2b_first_cnt",   {24'd0, a_cnt},    32'd2);
        drv_a(0, 6'd0, 0);
        chk("b2b_second_valid", {31'd0, a_ovalid}, 32'd1);
        chk("b2b_second_list",  {14'd0, a_list},   {14'd0, 6'd0, 6'd0, 6'd9});
        chk("b2b_second_num",   {30'd0, a_num},    32'd1);
        chk("b2b_second_cnt",   {24'd0, a_cnt},    32'd1);
        drv_a(0, 6'd0, 0);
        chk("b2b_pulse_end", {31'd0, a_ovalid}, 32'd0);

        // Reset mid-frame: 20, 21, reset with a valid sample, then 4(last)
        drv_a(1, 6'd20, 0);
        drv_a(1, 6'd21, 0);
        @(negedge clk);
        chk("mid_no_valid", {31'd0, a_ovalid}, 32'd0);
        rst = 1'b1; a_valid = 1'b1; a_data = 6'd30; a_last = 1'b1;
        drv_a(0, 6'd0, 0);
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, a_ovalid}, 32'd0);
        chk("mid_rst_list",  {14'd0, a_list},   32'd0);
        chk("mid_rst_num",   {30'd0, a_num},    32'd0);
        chk("mid_rst_cnt",   {24'd0, a_cnt},    32'd0);
        drv_a(1, 6'd4, 1);
        drv_a(0, 6'd0, 0);
        chk("mid_valid", {31'd0, a_ovalid}, 32'd1);
        chk("mid_list",  {14'd0, a_list},   {14'd0, 6'd0, 6'd0, 6'd4});
        chk("mid_num",   {30'd0, a_num},    32'd1);
        chk("mid_cnt",   {24'd0, a_cnt},    32'd1);

        // Ascending K=4: 7, -1, 7, 0(last) -> -1, 0, 7, 7
        drv_b(1, 6'd7, 0);
        drv_b(1, 6'b111111, 0);
        drv_b(1, 6'd7, 0);
        drv_b(1, 6'd0, 1);
        drv_b(0, 6'd0, 0);
        chk("asc_valid", {31'd0, b_ovalid}, 32'd1);
        chk("asc_list",  {8'd0, b_list},    {8'd0, 6'd7, 6'd7, 6'd0, 6'b111111});
        chk("asc_num",   {29'd0, b_num},    32'd4);
        chk("asc_cnt",   {24'd0, b_cnt},    32'd4);

        // Saturating 2-bit counter: six -10 samples with gaps
        for (int i = 0; i < 6; i++) begin
            drv_c(1, 6'b110110, (i == 5) ? 1'b1 : 1'b0);
            if (i != 5) begin
                drv_c(0, 6'd0, 0);
                drv_c(0, 6'd0, 0);
            end
        end
        drv_c(0, 6'd0, 0);
        chk("sat_valid", {31'd0, c_ovalid}, 32'd1);
        chk("sat_list",  {14'd0, c_list},   {14'd0, 6'b110110, 6'b110110, 6'b110110});
        chk("sat_num",   {30'd0, c_num},    32'd3);
        chk("sat_cnt",   {30'd0, c_cnt},    32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
